// File: rtl/score_pkg.sv
// Shared definitions for the score display: bus opcodes, 7-segment glyphs
// (active low, {dp,g,f,e,d,c,b,a}) and the decimal-to-BCD helper.
package score_pkg;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_INC = 2'b01;
  localparam logic [1:0] OP_DEC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Widest score supported by the BCD helper.
  localparam int MAX_DIGITS = 4;

  // Glyph for one BCD nibble; non-decimal nibbles show a dash.
  function automatic logic [7:0] seg_of(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_of = 8'hC0;
      4'd1:    seg_of = 8'hF9;
      4'd2:    seg_of = 8'hA4;
      4'd3:    seg_of = 8'hB0;
      4'd4:    seg_of = 8'h99;
      4'd5:    seg_of = 8'h92;
      4'd6:    seg_of = 8'h82;
      4'd7:    seg_of = 8'hF8;
      4'd8:    seg_of = 8'h80;
      4'd9:    seg_of = 8'h90;
      default: seg_of = SEG_DASH;
    endcase
  endfunction

  // Decimal to packed BCD, evaluated at elaboration for the winning score.
  function automatic logic [4*MAX_DIGITS-1:0] to_bcd(input int unsigned value);
    int unsigned rem;
    rem    = value;
    to_bcd = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      to_bcd[4*i +: 4] = 4'(rem % 10);
      rem              = rem / 10;
    end
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Saturating multi-digit BCD up/down counter with clear, one per player.
// Increment stops at all nines, decrement stops at zero, clear has priority.
module bcd_counter #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc_i,
  input  logic                dec_i,
  input  logic                clr_i,
  output logic [4*DIGITS-1:0] value_o,
  output logic                is_max_o
);

  localparam int             W         = 4 * DIGITS;
  localparam logic [W-1:0]   ALL_NINES = {DIGITS{4'h9}};

  logic [W-1:0] value_q, value_d;
  logic         carry;

  // Next value: ripple a carry (or borrow) upward from the units digit.
  always_comb begin
    // NOTE: carry is a blocking temporary that must ripple digit to digit
    // within one evaluation, and every comb output gets a default first so
    // no latch is inferred.
    value_d = value_q;
    carry   = 1'b1;
    if (clr_i) begin
      value_d = '0;
    end else if (inc_i && (value_q != ALL_NINES)) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (value_q[4*i +: 4] == 4'd9) begin
            value_d[4*i +: 4] = 4'd0;
          end else begin
            value_d[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end else if (dec_i && (value_q != '0)) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (value_q[4*i +: 4] == 4'd0) begin
            value_d[4*i +: 4] = 4'd9;
          end else begin
            value_d[4*i +: 4] = value_q[4*i +: 4] - 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
  end

  // Score register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments, and rst is only
    // looked at on the clock edge, so it is an ordinary synchronous input.
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value_o  = value_q;
  assign is_max_o = (value_q == ALL_NINES);

endmodule

// File: rtl/score_display_mux.sv
// Multi-player BCD scoreboard: bus commands update per-player counters, a
// registered detector latches the winner, and a prescaled scan engine
// time-multiplexes every digit onto one active-low 7-segment bank.
module score_display_mux
  import score_pkg::*;
#(
  parameter int PLAYERS   = 2,
  parameter int DIGITS    = 2,
  parameter int DIV_BITS  = 16,
  parameter int WIN_SCORE = 99,
  parameter int BLANK_LZ  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sel,
  input  logic [1:0]                 addr,
  input  logic [1:0]                 data_in,
  output logic [7:0]                 cathode,
  output logic [PLAYERS*DIGITS-1:0]  anode,
  output logic                       game_over,
  output logic [1:0]                 winner_id
);

  localparam int SLOTS = PLAYERS * DIGITS;
  localparam int IDX_W = $clog2(SLOTS);
  localparam int W     = 4 * DIGITS;

  localparam logic [4*MAX_DIGITS-1:0] WIN_FULL   = to_bcd(WIN_SCORE);
  localparam logic [W-1:0]            WIN_BCD    = WIN_FULL[W-1:0];
  localparam logic [W-1:0]            ALL_NINES  = {DIGITS{4'h9}};
  localparam bit                      WIN_IS_MAX = (WIN_BCD == ALL_NINES);
  // Slot 0 is the top digit of the last player; with zero scores it is
  // blanked unless it is also that player's units digit.
  localparam logic [7:0] RST_CATHODE =
    ((BLANK_LZ != 0) && (DIGITS > 1)) ? SEG_BLANK : seg_of(4'd0);

  logic                 cmd_valid, op_inc, op_dec, op_clr;
  logic [PLAYERS-1:0]   inc_v, dec_v, clr_v, is_max, win_hit;
  logic [W-1:0]         score [PLAYERS];
  logic [SLOTS-1:0]     blank_map;
  logic                 run;
  logic [3:0]           nib;
  logic                 tick;

  logic [DIV_BITS-1:0]  presc_q, presc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SLOTS-1:0]     anode_q, anode_d;
  logic [7:0]           cathode_q, cathode_d;
  logic                 game_over_q, game_over_d;
  logic [1:0]           winner_q, winner_d;

  // Decode the bus command into per-player strobes; inc/dec freeze at game
  // over, and a clear during game over resets every player.
  always_comb begin
    cmd_valid = sel && (32'(addr) < PLAYERS);
    op_inc    = 1'b0;
    op_dec    = 1'b0;
    op_clr    = 1'b0;
    if (cmd_valid) begin
      case (data_in)
        OP_NOP: ;
        OP_INC: op_inc = 1'b1;
        OP_DEC: op_dec = 1'b1;
        OP_CLR: op_clr = 1'b1;
      endcase
    end
    for (int p = 0; p < PLAYERS; p++) begin
      inc_v[p] = op_inc && !game_over_q && (addr == 2'(p));
      dec_v[p] = op_dec && !game_over_q && (addr == 2'(p));
      clr_v[p] = op_clr && (game_over_q || (addr == 2'(p)));
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    bcd_counter #(.DIGITS(DIGITS)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc_i    (inc_v[p]),
      .dec_i    (dec_v[p]),
      .clr_i    (clr_v[p]),
      .value_o  (score[p]),
      .is_max_o (is_max[p])
    );
    assign win_hit[p] = WIN_IS_MAX ? is_max[p] : (score[p] == WIN_BCD);
  end

  // Winner latch: set from the registered scores, released by a clear.
  always_comb begin
    game_over_d = game_over_q;
    winner_d    = winner_q;
    if (game_over_q) begin
      if (op_clr) begin
        game_over_d = 1'b0;
        winner_d    = '0;
      end
    end else begin
      for (int p = 0; p < PLAYERS; p++) begin
        if (win_hit[p] && !clr_v[p]) begin
          game_over_d = 1'b1;
          winner_d    = 2'(p);
        end
      end
    end
  end

  // Scan engine: free-running prescaler, slot index advances on each wrap.
  always_comb begin
    tick    = &presc_q;
    presc_d = presc_q + DIV_BITS'(1);
    idx_d   = idx_q;
    if (tick) idx_d = (idx_q == IDX_W'(SLOTS - 1)) ? '0 : idx_q + IDX_W'(1);
  end

  // Leading-zero map: a digit blanks when it and all higher digits are zero.
  always_comb begin
    blank_map = '0;
    run       = 1'b1;
    for (int p = 0; p < PLAYERS; p++) begin
      run = 1'b1;
      for (int d = DIGITS - 1; d >= 0; d--) begin
        run = run && (score[p][4*d +: 4] == 4'd0);
        if ((BLANK_LZ != 0) && (d != 0)) blank_map[p*DIGITS + d] = run;
      end
    end
  end

  // Glyph and digit enable for the current slot (highest player first).
  always_comb begin
    anode_d   = '1;
    cathode_d = SEG_DASH;
    nib       = '0;
    for (int k = 0; k < SLOTS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        anode_d[k] = 1'b0;
        nib        = score[PLAYERS-1-k/DIGITS][4*(DIGITS-1-k%DIGITS) +: 4];
        cathode_d  = blank_map[SLOTS-1-k] ? SEG_BLANK : seg_of(nib);
      end
    end
  end

  // Scan, display and winner registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= '0;
      idx_q       <= '0;
      anode_q     <= ~SLOTS'(1);
      cathode_q   <= RST_CATHODE;
      game_over_q <= 1'b0;
      winner_q    <= '0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      anode_q     <= anode_d;
      cathode_q   <= cathode_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign anode     = anode_q;
  assign cathode   = cathode_q;
  assign game_over = game_over_q;
  assign winner_id = winner_q;

endmodule

// File: tb/tb_score_display_mux.sv
// Directed bench for score_display_mux: a 2x2 instance and a 3x3 instance
// (WIN_SCORE=150), both with a 4-cycle scan slot. Scores are read back
// through the multiplexed display and compared with hand-derived glyphs.
module tb_score_display_mux;

  localparam logic [1:0] INC = 2'b01;
  localparam logic [1:0] DEC = 2'b10;
  localparam logic [1:0] CLR = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel_a, sel_b;
  logic [1:0] addr_a, data_a, addr_b, data_b;
  logic [7:0] cath_a, cath_b;
  logic [3:0] an_a;
  logic [8:0] an_b;
  logic       go_a, go_b;
  logic [1:0] win_a, win_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] scan_cath [4] = '{8'h99, 8'hA4, 8'hFF, 8'hF8};

  always #5 clk = ~clk;

  score_display_mux #(
    .PLAYERS(2), .DIGITS(2), .DIV_BITS(2), .WIN_SCORE(99), .BLANK_LZ(1)
  ) dut_a (
    .clk(clk), .rst(rst), .sel(sel_a), .addr(addr_a), .data_in(data_a),
    .cathode(cath_a), .anode(an_a), .game_over(go_a), .winner_id(win_a)
  );

  score_display_mux #(
    .PLAYERS(3), .DIGITS(3), .DIV_BITS(2), .WIN_SCORE(150), .BLANK_LZ(1)
  ) dut_b (
    .clk(clk), .rst(rst), .sel(sel_b), .addr(addr_b), .data_in(data_b),
    .cathode(cath_b), .anode(an_b), .game_over(go_b), .winner_id(win_b)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag, input int k);
    checks++;
    errors++;
    $display("FAIL %s: observed timeout expected slot %0d", tag, k);
  endtask

  function automatic logic [7:0] glyph(input int n);
    case (n)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hBF;
    endcase
  endfunction

  // Expected glyph of decimal digit d of score: blank when score < 10^d.
  function automatic logic [7:0] exp_glyph(input int score, input int d);
    int p10 = 1;
    for (int i = 0; i < d; i++) p10 *= 10;
    if (d > 0 && score < p10) return 8'hFF;
    return glyph((score / p10) % 10);
  endfunction

  // One command per call: driven at a falling edge, result visible at the next.
  task automatic cmd_a(input logic [1:0] a, input logic [1:0] op);
    sel_a = 1'b1; addr_a = a; data_a = op;
    @(negedge clk);
    sel_a = 1'b0; data_a = 2'b00;
  endtask

  task automatic cmd_b(input logic [1:0] a, input logic [1:0] op);
    sel_b = 1'b1; addr_b = a; data_b = op;
    @(negedge clk);
    sel_b = 1'b0; data_b = 2'b00;
  endtask

  task automatic read_a(input int k, output logic [7:0] cath, output bit ok);
    logic [3:0] want;
    want = ~(4'b0001 << k);
    ok   = 1'b0;
    cath = 'x;
    @(negedge clk);
    for (int i = 0; i < 100 && !ok; i++) begin
      if (an_a === want) begin ok = 1'b1; cath = cath_a; end
      else @(negedge clk);
    end
  endtask

  task automatic read_b(input int k, output logic [7:0] cath, output bit ok);
    logic [8:0] want;
    want = ~(9'b0_0000_0001 << k);
    ok   = 1'b0;
    cath = 'x;
    @(negedge clk);
    for (int i = 0; i < 100 && !ok; i++) begin
      if (an_b === want) begin ok = 1'b1; cath = cath_b; end
      else @(negedge clk);
    end
  endtask

  task automatic slot_a(input string tag, input int player, input int digit,
                        input int score);
    logic [7:0] c;
    bit         ok;
    int         k;
    k = (1 - player) * 2 + (1 - digit);
    read_a(k, c, ok);
    if (!ok) timeout(tag, k);
    else     check(tag, c, exp_glyph(score, digit));
  endtask

  task automatic slot_b(input string tag, input int player, input int digit,
                        input int score);
    logic [7:0] c;
    bit         ok;
    int         k;
    k = (2 - player) * 3 + (2 - digit);
    read_b(k, c, ok);
    if (!ok) timeout(tag, k);
    else     check(tag, c, exp_glyph(score, digit));
  endtask

  initial begin
    logic [3:0] want;
    logic [3:0] prev;
    logic [7:0] dummy;
    bit         found;
    bit         ok;

    rst = 1'b1;
    sel_a = 1'b0; addr_a = '0; data_a = '0;
    sel_b = 1'b0; addr_b = '0; data_b = '0;
    repeat (2) @(negedge clk);
    check("rst_anode_a", an_a, 4'b1110);
    check("rst_cath_a", cath_a, 8'hFF);
    check("rst_go_a", go_a, 1'b0);
    check("rst_win_a", win_a, 2'd0);
    check("rst_anode_b", an_b, 9'b1_1111_1110);
    check("rst_cath_b", cath_b, 8'hFF);
    rst = 1'b0;

    // P0=7, P1=42, then one full scan cycle-by-cycle.
    repeat (7) cmd_a(2'd0, INC);
    repeat (42) cmd_a(2'd1, INC);
    found = 1'b0;
    prev  = an_a;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (an_a === 4'b1110 && prev !== 4'b1110) found = 1'b1;
      prev = an_a;
    end
    if (!found) timeout("scan_align", 0);
    for (int c = 0; c < 16; c++) begin
      want = ~(4'b0001 << (c / 4));
      check("scan_anode", an_a, want);
      check("scan_cath", cath_a, scan_cath[c/4]);
      @(negedge clk);
    end

    // Borrow 10 -> 09 and floor at 00 on P1.
    cmd_a(2'd1, CLR);
    repeat (10) cmd_a(2'd1, INC);
    slot_a("p1_10_tens", 1, 1, 10);
    slot_a("p1_10_units", 1, 0, 10);
    cmd_a(2'd1, DEC);
    slot_a("p1_09_tens", 1, 1, 9);
    slot_a("p1_09_units", 1, 0, 9);
    repeat (10) cmd_a(2'd1, DEC);
    slot_a("p1_floor_tens", 1, 1, 0);
    slot_a("p1_floor_units", 1, 0, 0);

    // Out-of-range addresses are ignored.
    cmd_a(2'd3, INC);
    cmd_a(2'd2, CLR);
    slot_a("bad_addr_p0", 0, 0, 7);
    slot_a("bad_addr_p1", 1, 0, 0);

    // P0 reaches 99: game over one cycle after the score update.
    cmd_a(2'd0, CLR);
    repeat (98) cmd_a(2'd0, INC);
    check("go_at_98", go_a, 1'b0);
    cmd_a(2'd0, INC);
    check("go_score_cycle", go_a, 1'b0);
    @(negedge clk);
    check("go_set", go_a, 1'b1);
    check("winner_p0", win_a, 2'd0);
    repeat (101) cmd_a(2'd0, INC);
    cmd_a(2'd0, DEC);
    cmd_a(2'd1, INC);
    slot_a("sat_tens", 0, 1, 99);
    slot_a("sat_units", 0, 0, 99);
    slot_a("frozen_p1", 1, 0, 0);
    check("go_held", go_a, 1'b1);

    // Clear to P1 during game over resets everyone.
    cmd_a(2'd1, CLR);
    check("go_cleared", go_a, 1'b0);
    check("win_cleared", win_a, 2'd0);
    slot_a("clr_all_p0_units", 0, 0, 0);
    slot_a("clr_all_p0_tens", 0, 1, 0);
    cmd_a(2'd1, INC);
    slot_a("p1_after_units", 1, 0, 1);
    slot_a("p1_after_tens", 1, 1, 1);

    // Three players, three digits, win at 150 by P2.
    repeat (150) cmd_b(2'd2, INC);
    check("b_go_score_cycle", go_b, 1'b0);
    @(negedge clk);
    check("b_go_set", go_b, 1'b1);
    check("b_winner_p2", win_b, 2'd2);
    slot_b("b_p2_hundreds", 2, 2, 150);
    slot_b("b_p2_tens", 2, 1, 150);
    cmd_b(2'd0, CLR);
    check("b_go_cleared", go_b, 1'b0);
    slot_b("b_p2_cleared", 2, 0, 0);
    repeat (100) cmd_b(2'd0, INC);
    slot_b("b_p0_100_h", 0, 2, 100);
    slot_b("b_p0_100_t", 0, 1, 100);
    slot_b("b_p0_100_u", 0, 0, 100);
    cmd_b(2'd0, DEC);
    slot_b("b_p0_099_h", 0, 2, 99);
    slot_b("b_p0_099_t", 0, 1, 99);
    slot_b("b_p0_099_u", 0, 0, 99);

    // Reset mid-scan.
    repeat (3) cmd_a(2'd0, INC);
    read_a(2, dummy, ok);
    if (!ok) timeout("mid_scan_wait", 2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_anode", an_a, 4'b1110);
    check("mid_rst_cath", cath_a, 8'hFF);
    check("mid_rst_go", go_a, 1'b0);
    rst = 1'b0;
    slot_a("mid_rst_p0", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
